// File: rtl/dna_id_reporter.sv
// Reads the 57-bit device ID out of DNA_PORT and reports it over the uart_tx byte
// interface as 15 upper-case hex digits, optionally followed by CR LF.
module dna_id_reporter #(
  parameter int AUTO_START    = 1,
  parameter int REPEAT_CYCLES = 50_000_000,
  parameter int SEND_CRLF     = 1,
  parameter int BUSY_LAT      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_dna_dout,
  output logic        o_dna_read,
  output logic        o_dna_shift,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_we,
  output logic [56:0] o_dna,
  output logic        o_dna_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_TXWAIT, S_TXSTB, S_TXLAT, S_TXBUSY, S_FIN
  } state_t;

  localparam logic [4:0] LAST_BYTE = (SEND_CRLF != 0) ? 5'd16 : 5'd14;
  localparam int LAT_W = (BUSY_LAT > 1) ? $clog2(BUSY_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'((BUSY_LAT > 0) ? BUSY_LAT - 1 : 0);

  state_t           state, state_nx;
  logic             first_cycle;
  logic [5:0]       bit_cnt;
  logic [4:0]       byte_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [55:0]      shreg;
  logic             period_tick;
  logic             trigger;

  // Byte n of the report: nibble n of the 60-bit zero-extended ID, MSB first, then CR LF.
  function automatic logic [7:0] hex_byte(input logic [56:0] id, input logic [4:0] idx);
    logic [59:0] shifted;
    logic [3:0]  nib;
    shifted = {3'b000, id} << {idx, 2'b00};
    nib     = shifted[59:56];
    case (idx)
      5'd15:   hex_byte = 8'h0D;
      5'd16:   hex_byte = 8'h0A;
      default: hex_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    endcase
  endfunction

  if (REPEAT_CYCLES > 0) begin : g_period
    localparam int PW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(REPEAT_CYCLES - 1);
    logic [PW-1:0] period_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                 period_cnt <= '0;
      else if (period_cnt == P_MAX) period_cnt <= '0;
      else                          period_cnt <= period_cnt + PW'(1);
    end
    assign period_tick = (period_cnt == P_MAX);
  end else begin : g_no_period
    assign period_tick = 1'b0;
  end

  assign trigger = i_start | period_tick | first_cycle;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // uart_tx handshake: a byte is offered (o_tx_we for one cycle) only after i_tx_busy was
  // seen low; busy is then ignored for BUSY_LAT cycles and the next byte waits for it to drop.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (trigger) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_SHIFT;
      S_SHIFT:  if (bit_cnt == 6'd56) state_nx = S_TXWAIT;
      S_TXWAIT: if (!i_tx_busy) state_nx = S_TXSTB;
      S_TXSTB:  state_nx = (BUSY_LAT > 0) ? S_TXLAT : S_TXBUSY;
      S_TXLAT:  if (lat_cnt == LAT_MAX) state_nx = S_TXBUSY;
      S_TXBUSY: if (!i_tx_busy) state_nx = (byte_cnt == LAST_BYTE) ? S_FIN : S_TXWAIT;
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_dna_read  = (state == S_LOAD);
    o_dna_shift = (state == S_SHIFT) && (bit_cnt != 6'd56);
    o_tx_we     = (state == S_TXSTB);
    o_busy      = (state != S_IDLE);
    o_done      = (state == S_FIN);
    o_dbg_state = state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      first_cycle <= (AUTO_START != 0);
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      lat_cnt     <= '0;
      shreg       <= '0;
      o_dna       <= '0;
      o_dna_valid <= 1'b0;
      o_tx_data   <= '0;
    end else begin
      first_cycle <= 1'b0;
      case (state)
        S_LOAD: bit_cnt <= '0;
        S_SHIFT: begin
          shreg   <= {shreg[54:0], i_dna_dout};
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd56) begin
            o_dna       <= {shreg, i_dna_dout};
            o_dna_valid <= 1'b1;
            byte_cnt    <= '0;
          end
        end
        S_TXWAIT: if (!i_tx_busy) o_tx_data <= hex_byte(o_dna, byte_cnt);
        S_TXSTB:  lat_cnt <= '0;
        S_TXLAT:  lat_cnt <= lat_cnt + LAT_W'(1);
        S_TXBUSY: if (!i_tx_busy && byte_cnt != LAST_BYTE) byte_cnt <= byte_cnt + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_id_reporter.sv
// Bench for dna_id_reporter: three instances (CRLF, no CRLF, periodic) against a DNA_PORT
// model, a uart_tx busy model and a cycle-level behavioural reference.
module tb_dna_id_reporter;
  localparam int N = 3;
  localparam int AUTO_C [N] = '{1, 1, 1};
  localparam int REP_C  [N] = '{0, 0, 5000};
  localparam int CRLF_C [N] = '{1, 0, 1};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] rst_n = '1;

  logic [N-1:0] start, hold_busy, busy_in, dna_dout, dna_read, dna_shift;
  logic [N-1:0] tx_we, dna_valid, busy, done;
  logic [7:0]   tx_data   [N];
  logic [56:0]  dna       [N];
  logic [2:0]   dbg_state [N];
  logic [56:0]  sim_dna   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    int idx = 0;
    int busy_cnt = 0;
    logic busy_r = 1'b0;
    logic [56:0] dna_sh;
    assign dna_sh      = sim_dna[g] << idx;
    assign dna_dout[g] = (idx < 57) ? dna_sh[56] : 1'b0;
    assign busy_in[g]  = busy_r | hold_busy[g];

    always @(posedge clk) begin
      if (dna_read[g])                  idx <= 0;
      else if (dna_shift[g] && idx < 57) idx <= idx + 1;
    end

    always @(posedge clk) begin
      if (tx_we[g]) begin
        busy_r   <= 1'b1;
        busy_cnt <= $urandom_range(8, 2);
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end else begin
        busy_cnt <= 0;
        busy_r   <= 1'b0;
      end
    end

    dna_id_reporter #(
      .AUTO_START(AUTO_C[g]), .REPEAT_CYCLES(REP_C[g]), .SEND_CRLF(CRLF_C[g]), .BUSY_LAT(2)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n[g]), .i_start(start[g]), .i_dna_dout(dna_dout[g]),
      .o_dna_read(dna_read[g]), .o_dna_shift(dna_shift[g]), .i_tx_busy(busy_in[g]),
      .o_tx_data(tx_data[g]), .o_tx_we(tx_we[g]), .o_dna(dna[g]), .o_dna_valid(dna_valid[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_dbg_state(dbg_state[g])
    );
  end

  // scoreboard / reference model state
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int timeouts = 0;
  bit do_final = 1'b0;
  bit final_done = 1'b0;
  bit model_busy [N], pending [N], prev_rst_low [N], prev_busy_in [N], exp_valid [N];
  int shift_left [N], cap_cnt [N], cyc_since [N], trig_cnt [N], abort_cnt [N];
  int done_seen [N], reads_seen [N], bytes_sent [N], rep_bytes [N];
  logic [56:0] cap [N], exp_dna [N];
  logic [7:0]  exp_q [N][$];
  string rx_str [N], first_str [N];
  int read_times [$];

  task automatic chk(input int g, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", name, g, cyc, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=\"%s\" expected=\"%s\"", name, act, exp);
    end
  endtask

  // Expected report: ID as 15 upper-case hex digits (most significant first), then CR LF.
  task automatic load_exp(input int g, input logic [56:0] id);
    string hex;
    logic [59:0] v;
    hex = "0123456789ABCDEF";
    v = {3'b000, id};
    exp_q[g].delete();
    for (int n = 0; n < 15; n++) exp_q[g].push_back(hex[int'((v / (60'd1 << (4 * (14 - n)))) % 16)]);
    if (CRLF_C[g] != 0) begin
      exp_q[g].push_back(8'h0D);
      exp_q[g].push_back(8'h0A);
    end
  endtask

  // compare process: every cycle, every instance
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int g = 0; g < N; g++) begin
        bit trig;
        logic [7:0] eb;
        if (!rst_n[g]) begin
          chk(g, "rst_dna", 64'(dna[g]), 64'd0);
          chk(g, "rst_ctrl", {tx_data[g], dna_read[g], dna_shift[g], tx_we[g], dna_valid[g], busy[g], done[g]}, 64'd0);
          if (model_busy[g]) abort_cnt[g]++;
          model_busy[g] = 0; pending[g] = 0; shift_left[g] = 0; cap_cnt[g] = 0;
          exp_dna[g] = '0; exp_valid[g] = 0; exp_q[g].delete();
          prev_rst_low[g] = 1; cyc_since[g] = 0; prev_busy_in[g] = busy_in[g];
          continue;
        end
        if (cap_cnt[g] > 0) begin
          cap_cnt[g]--;
          if (cap_cnt[g] == 0) begin
            exp_dna[g] = cap[g];
            exp_valid[g] = 1;
          end
        end
        chk(g, "read", 64'(dna_read[g]), 64'(pending[g]));
        chk(g, "shift", 64'(dna_shift[g]), 64'(shift_left[g] > 0));
        chk(g, "busy", 64'(busy[g]), 64'(model_busy[g]));
        chk(g, "dna", 64'(dna[g]), 64'(exp_dna[g]));
        chk(g, "dna_valid", 64'(dna_valid[g]), 64'(exp_valid[g]));
        if (shift_left[g] > 0) shift_left[g]--;
        if (pending[g]) begin
          pending[g] = 0;
          reads_seen[g]++;
          shift_left[g] = 56;
          cap_cnt[g] = 58;
          cap[g] = sim_dna[g];
          load_exp(g, sim_dna[g]);
          rx_str[g] = "";
          rep_bytes[g] = 0;
          if (g == 2) read_times.push_back(cyc);
        end
        if (tx_we[g]) begin
          chk(g, "we_while_busy", 64'(prev_busy_in[g]), 64'd0);
          chk(g, "byte_expected", 64'(exp_q[g].size() > 0), 64'd1);
          if (exp_q[g].size() > 0) begin
            eb = exp_q[g].pop_front();
            chk(g, "tx_byte", 64'(tx_data[g]), 64'(eb));
          end
          if (rx_str[g].len() < 15) rx_str[g] = $sformatf("%s%c", rx_str[g], tx_data[g]);
          bytes_sent[g]++;
          rep_bytes[g]++;
        end
        trig = !model_busy[g] && (start[g] || (AUTO_C[g] != 0 && prev_rst_low[g]) ||
               (REP_C[g] > 0 && (cyc_since[g] % (REP_C[g] > 0 ? REP_C[g] : 1)) == REP_C[g] - 1));
        if (done[g]) begin
          chk(g, "done_all_bytes", 64'(exp_q[g].size()), 64'd0);
          chk(g, "bytes_per_report", 64'(rep_bytes[g]), (CRLF_C[g] != 0) ? 64'd17 : 64'd15);
          if (done_seen[g] == 0) begin
            first_str[g] = rx_str[g];
            if (g == 0) chk(g, "dna_pin", 64'(dna[g]), 64'h123456789ABCDEF);
          end
          done_seen[g]++;
          model_busy[g] = 0;
        end
        if (trig) begin
          model_busy[g] = 1;
          pending[g] = 1;
          trig_cnt[g]++;
        end
        prev_busy_in[g] = busy_in[g];
        prev_rst_low[g] = 0;
        cyc_since[g]++;
      end
      if (do_final && !final_done) begin
        final_done = 1;
        for (int g = 0; g < N; g++)
          chk(g, "report_count", 64'(done_seen[g]), 64'(trig_cnt[g] - abort_cnt[g]));
        chk_str("first_report_inst0", first_str[0], "123456789ABCDEF");
        chk_str("first_report_inst1", first_str[1], "000000000000000");
        chk(2, "period_reports", 64'(read_times.size() >= 4), 64'd1);
        for (int i = 2; i < read_times.size(); i++)
          chk(2, "period_spacing", 64'(read_times[i] - read_times[i-1]), 64'd5000);
        chk(0, "timeouts", 64'(timeouts), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input int g);
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target, input int budget);
    int n;
    n = 0;
    while (done_seen[g] < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_seen[g] < target) begin
      timeouts++;
      $display("FAIL wait_done inst=%0d got=%0d expected=%0d", g, done_seen[g], target);
    end
  endtask

  task automatic wait_bytes(input int g, input int target, input int budget);
    int n;
    n = 0;
    while (bytes_sent[g] < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (bytes_sent[g] < target) begin
      timeouts++;
      $display("FAIL wait_bytes inst=%0d got=%0d expected=%0d", g, bytes_sent[g], target);
    end
  endtask

  initial begin
    int r0;
    int n;
    rst_n = '0;
    start = '0;
    hold_busy = '0;
    sim_dna[0] = 57'h123456789ABCDEF;
    sim_dna[1] = 57'h0;
    sim_dna[2] = 57'({$urandom(), $urandom()});
    repeat (5) @(posedge clk);
    #1 rst_n = '1;

    // auto report after reset
    wait_done(0, 1, 3000);

    // uart held busy for 1000 cycles after byte 5
    sim_dna[0] = 57'({$urandom(), $urandom()});
    r0 = bytes_sent[0];
    pulse_start(0);
    wait_bytes(0, r0 + 6, 2000);
    hold_busy[0] = 1'b1;
    repeat (1000) @(posedge clk);
    #1 hold_busy[0] = 1'b0;
    wait_done(0, 2, 3000);

    // extra start pulses during a report are dropped
    sim_dna[0] = 57'({$urandom(), $urandom()});
    pulse_start(0);
    repeat (5) @(posedge clk);
    pulse_start(0);
    repeat (25) @(posedge clk);
    pulse_start(0);
    repeat (60) @(posedge clk);
    pulse_start(0);
    wait_done(0, 3, 3000);

    // random IDs, including an all-F value
    for (int i = 0; i < 4; i++) begin
      sim_dna[0] = (i == 0) ? {57{1'b1}} : 57'({$urandom(), $urandom()});
      repeat ($urandom_range(6, 1)) @(posedge clk);
      #1;
      pulse_start(0);
      wait_done(0, 4 + i, 3000);
    end

    // reset in SHIFT at k=30, then the auto report must bring a fresh, correct ID
    sim_dna[0] = 57'({$urandom(), $urandom()});
    r0 = reads_seen[0];
    pulse_start(0);
    n = 0;
    while (reads_seen[0] == r0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (reads_seen[0] == r0) begin
      timeouts++;
      $display("FAIL wait_read inst=0 got=%0d expected=%0d", reads_seen[0], r0 + 1);
    end
    repeat (30) @(posedge clk);
    #1 rst_n[0] = 1'b0;
    sim_dna[0] = 57'({$urandom(), $urandom()});
    repeat (3) @(posedge clk);
    #1 rst_n[0] = 1'b1;
    wait_done(0, 8, 3000);

    // let the periodic instance run four reports
    n = 0;
    while (cyc < 15400 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1 do_final = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
